// File: rtl/id_stage_pkg.sv
// Shared instruction definitions and constants for the decode stage.
// Optional RV32M decode is controlled by macro ID_RV32M_EN (see id_decoder).
package id_stage_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
        CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_MULDIV
    } cls_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;

    // Base integer ALU op from funct3; alt selects SUB/SRA.
    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I instruction decoder (inst -> decoded fields).
// Define ID_RV32M_EN to decode RV32M; otherwise those encodings are illegal.
module id_decoder
    import id_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
) (
    input  logic [31:0]     inst,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            rd_we,
    output logic [XLEN-1:0] imm,
    output alu_op_e         alu_op,
    output cls_e            cls,
    output logic            illegal
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;

    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign rs1 = RA_W'(inst[19:15]);
    assign rs2 = RA_W'(inst[24:20]);
    assign rd  = RA_W'(inst[11:7]);
    assign imm = XLEN'($signed(imm32));

    always_comb begin
        imm32   = '0;
        cls     = CLS_ALU_R;
        alu_op  = ALU_ADD;
        rs1_en  = 1'b0;
        rs2_en  = 1'b0;
        rd_we   = 1'b0;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (inst[6:0])
                OPC_OP: begin
                    cls = CLS_ALU_R; rs1_en = 1'b1; rs2_en = 1'b1; rd_we = 1'b1;
                    if (f7 == 7'b0000000)
                        alu_op = base_alu(f3, 1'b0);
                    else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                        alu_op = base_alu(f3, 1'b1);
`ifdef ID_RV32M_EN
                    else if (f7 == 7'b0000001) begin
                        cls    = CLS_MULDIV;
                        alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, f3});
                    end
`endif
                    else
                        illegal = 1'b1;
                end
                OPC_OP_IMM: begin
                    cls = CLS_ALU_I; rs1_en = 1'b1; rd_we = 1'b1;
                    imm32  = {{20{inst[31]}}, inst[31:20]};
                    alu_op = base_alu(f3, inst[30] && f3 == 3'b101);
                    if (f3 == 3'b001 && f7 != 7'b0000000)
                        illegal = 1'b1;
                    if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                        illegal = 1'b1;
                end
                OPC_LOAD: begin
                    cls = CLS_LOAD; rs1_en = 1'b1; rd_we = 1'b1;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                    illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                end
                OPC_STORE: begin
                    cls = CLS_STORE; rs1_en = 1'b1; rs2_en = 1'b1;
                    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    illegal = f3[2] || (f3 == 3'b011);
                end
                OPC_BRANCH: begin
                    cls = CLS_BRANCH; rs1_en = 1'b1; rs2_en = 1'b1; alu_op = ALU_SUB;
                    imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                    illegal = (f3[2:1] == 2'b01);
                end
                OPC_JAL: begin
                    cls = CLS_JAL; rd_we = 1'b1;
                    imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OPC_JALR: begin
                    cls = CLS_JALR; rs1_en = 1'b1; rd_we = 1'b1;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                    illegal = (f3 != 3'b000);
                end
                OPC_LUI: begin
                    cls = CLS_LUI; rd_we = 1'b1; imm32 = {inst[31:12], 12'h000};
                end
                OPC_AUIPC: begin
                    cls = CLS_AUIPC; rd_we = 1'b1; imm32 = {inst[31:12], 12'h000};
                end
                OPC_SYSTEM: begin
                    // ECALL/EBREAK use no operands; CSR forms read rs1 only for register variants.
                    cls = CLS_SYSTEM;
                    if (f3 == 3'b100)
                        illegal = 1'b1;
                    else if (f3 != 3'b000) begin
                        rd_we  = 1'b1;
                        rs1_en = !f3[2];
                        imm32  = {{20{inst[31]}}, inst[31:20]};
                    end
                end
                OPC_MISC_MEM: begin
                    cls = CLS_SYSTEM;
                    illegal = (f3[2:1] != 2'b00);
                end
                default: illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            rs1_en = 1'b0;
            rs2_en = 1'b0;
            rd_we  = 1'b0;
        end
        if (inst[11:7] == 5'd0)
            rd_we = 1'b0;
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: id_decoder followed by a main/skid 2-entry output buffer.
// Define ID_RV32M_EN to enable RV32M decode.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned RA_W  = RA_W_DEF,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [RA_W-1:0]  out_rs1,
    output logic [RA_W-1:0]  out_rs2,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_rs1_en,
    output logic             out_rs2_en,
    output logic             out_rd_we,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_op,
    output logic [3:0]       out_cls,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic [3:0]      cls;
        logic            illegal;
    } bundle_t;

    bundle_t    dec_b, main_q, skid_q;
    alu_op_e    dec_alu;
    cls_e       dec_cls;
    occ_e       state, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic       accept, handoff;
    logic       load_main_dec, load_main_skid, load_skid;

    id_decoder #(.XLEN(XLEN), .RA_W(RA_W)) u_dec (
        .inst    (in_inst),
        .rs1     (dec_b.rs1),
        .rs2     (dec_b.rs2),
        .rd      (dec_b.rd),
        .rs1_en  (dec_b.rs1_en),
        .rs2_en  (dec_b.rs2_en),
        .rd_we   (dec_b.rd_we),
        .imm     (dec_b.imm),
        .alu_op  (dec_alu),
        .cls     (dec_cls),
        .illegal (dec_b.illegal)
    );

    assign dec_b.pc     = in_pc;
    assign dec_b.alu_op = dec_alu;
    assign dec_b.cls    = dec_cls;

    // Handshake flags decode only from the state register, so in_ready has no path from out_ready.
    assign out_valid = (state != OCC_EMPTY);
    assign in_ready  = (state != OCC_TWO);
    assign accept    = in_valid && in_ready && !flush;
    assign handoff   = out_valid && out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) begin
                    state_nxt     = OCC_ONE;
                    load_main_dec = 1'b1;
                end
                OCC_ONE: begin
                    if (accept && handoff)
                        load_main_dec = 1'b1;
                    else if (accept) begin
                        state_nxt = OCC_TWO;
                        load_skid = 1'b1;
                    end else if (handoff)
                        state_nxt = OCC_EMPTY;
                end
                OCC_TWO: if (handoff) begin
                    state_nxt      = OCC_ONE;
                    load_main_skid = 1'b1;
                end
                default: state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= OCC_EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_main_dec)
                main_q <= dec_b;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec_b;
            if (handoff && !flush)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_rs1_en  = main_q.rs1_en;
    assign out_rs2_en  = main_q.rs2_en;
    assign out_rd_we   = main_q.rd_we;
    assign out_imm     = main_q.imm;
    assign out_alu_op  = main_q.alu_op;
    assign out_cls     = main_q.cls;
    assign out_illegal = main_q.illegal;
    assign dec_count   = cnt_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/immediate width.
REQ-002 SHALL have parameter RA_W, default 5, register address width.
REQ-003 SHALL have parameter CNT_W, default 32, decode counter width.
REQ-004 SHALL have the following ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents inst.
- in_ready  out  1  stage can accept inst.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all buffered instructions.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  pc of bundle.
- out_rs1, out_rs2, out_rd  out  RA_W each  register addresses.
- out_rs1_en, out_rs2_en, out_rd_we  out  1 each  operand-use and writeback flags.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  5  ALU operation code.
- out_cls  out  4  class: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MULDIV.
- out_illegal  out  1  undecodable instruction.
- dec_count  out  CNT_W  bundles handed to execute.

Function
REQ-005 SHALL accept on in_valid&&in_ready and hand off on out_valid&&out_ready.
REQ-006 SHALL present the decoded bundle exactly 1 cycle after acceptance when the output is empty or draining.
REQ-007 SHALL hold a 2-entry buffer: main output register plus skid register.
- in_ready = !skid_valid, driven registered with no combinational path from out_ready.
REQ-008 SHALL route an input accepted while main is held (out_valid&&!out_ready) into skid.
- On the next handoff, skid moves to main and in_ready rises next cycle.
REQ-009 SHALL preserve strict program order; no bundle dropped or duplicated.
REQ-010 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-011 SHALL generate immediates from in_inst[6:0] as:
- I/S/B/U/J formats, sign-extended from inst[31] to XLEN.
- B/J with bit0=0.
- U with low 12 bits zero.
REQ-012 SHALL force out_rd_we=0 when rd=0 or class is STORE/BRANCH.
REQ-013 SHALL flag out_illegal for an unknown opcode, unsupported funct3/funct7 combination, or inst[1:0]!=2'b11.
- Illegal bundles still flow with all enables 0.
REQ-014 SHALL, on flush:
- clear main and skid valid next cycle and raise in_ready.
- drop an in_valid in the same cycle as flush.
- not count a handoff in the same cycle as flush.
REQ-015 SHALL increment dec_count by 1 per handoff, wrapping from all-ones to 0.
REQ-016 SHALL use a 3-state occupancy FSM EMPTY/ONE/TWO:
- EMPTY->ONE on accept.
- ONE->TWO on accept without handoff.
- ONE->EMPTY on handoff without accept.
- TWO->ONE on handoff.
- Any state ->EMPTY on flush.

Reset
REQ-017 SHALL, while rst=0, asynchronously force state EMPTY, out_valid=0, in_ready=1, all out_* and dec_count zero.
REQ-018 SHALL discard in-flight bundles on reset mid-operation; first accept is permitted the cycle after release.

Configuration
REQ-019 SHALL decode RV32M when macro ID_RV32M_EN is defined:
- opcode 0110011 with funct7=0000001 yields class MULDIV, alu_op MUL..REMU.
REQ-020 SHALL flag that encoding out_illegal when ID_RV32M_EN is undefined.

Structure
REQ-021 SHALL place opcode, class, and alu_op constants in the shared instruction definitions file.
- XLEN and register-address widths go in the shared constants file.
REQ-022 SHALL implement decode as one combinational sub-module id_decoder (inst -> bundle), instanced once ahead of the buffer.

Verification
REQ-023 SHALL cover the following directed scenarios:
- 0x00500093 (ADDI x1,x0,5), out_ready=1 -> next cycle cls=ALU_I, rd=1, rd_we=1, imm=5, rs1_en=1, dec_count=1.
- 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, cls=BRANCH, rd_we=0, rs2_en=1.
- out_ready=0, feed 3 insts back-to-back -> in_ready low after 2nd accept; release -> order 1,2,3, in_ready high 1 cycle after first handoff.
- 0x00000000 -> out_illegal=1, all enables 0; 0x022080B3 -> MULDIV with ID_RV32M_EN, illegal without.
- TWO state, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dec_count unchanged.
- rst=0 asserted mid-stream -> out_valid=0, dec_count=0 immediately (asynchronous).
